// File: rtl/instruction_fetch.sv
// Instruction fetch unit. A three-state sequencer (BOOT -> REQUEST -> HOLD)
// reads one instruction from memory and holds it for the control unit. The
// held instruction retires when enable is sampled high, and fetch then moves
// to either the branch target or the next sequential address.
module instruction_fetch #(
  parameter int                    DATA_WIDTH        = 32,
  parameter int                    INSTRUCTION_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR      = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         should_branch,
  input  logic [DATA_WIDTH-1:0]        branch_target,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_data,
  input  logic                         mem_ready,
  output logic                         mem_read,
  output logic [DATA_WIDTH-1:0]        mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0] Instruction,
  output logic                         instruction_valid,
  output logic [DATA_WIDTH-1:0]        pc,
  output logic [DATA_WIDTH-1:0]        pc_plus_one
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    REQUEST = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [DATA_WIDTH-1:0]          fetch_addr_q, fetch_addr_d;
  logic [DATA_WIDTH-1:0]          pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;

  // Link value; wraps silently at the top of the address space.
  assign pc_plus_one = pc_q + DATA_WIDTH'(1);

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      fetch_addr_q <= RESET_VECTOR;
      pc_q         <= RESET_VECTOR;
      instr_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
    end
  end

  // Next-state and output decode; mem_ready only matters in REQUEST and
  // enable/should_branch only matter in HOLD.
  always_comb begin
    state_d           = state_q;
    fetch_addr_d      = fetch_addr_q;
    pc_d              = pc_q;
    instr_d           = instr_q;
    mem_read          = 1'b0;
    instruction_valid = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = REQUEST;
      end
      REQUEST: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          instr_d = mem_data;
          pc_d    = fetch_addr_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instruction_valid = 1'b1;
        if (enable) begin
          fetch_addr_d = should_branch ? branch_target : pc_plus_one;
          state_d      = REQUEST;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign mem_addr    = fetch_addr_q;
  assign Instruction = instr_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a behavioural model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_instruction_fetch;

  localparam int DW = 32;
  localparam int IW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          should_branch = 1'b0;
  logic [DW-1:0] branch_target = '0;
  logic [IW-1:0] mem_data;
  logic          mem_ready = 1'b0;
  logic          mem_read;
  logic [DW-1:0] mem_addr;
  logic [IW-1:0] Instruction;
  logic          instruction_valid;
  logic [DW-1:0] pc;
  logic [DW-1:0] pc_plus_one;

  int total = 0;
  int bad   = 0;

  instruction_fetch #(
    .DATA_WIDTH(DW), .INSTRUCTION_WIDTH(IW), .RESET_VECTOR('0)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .should_branch(should_branch), .branch_target(branch_target),
    .mem_data(mem_data), .mem_ready(mem_ready), .mem_read(mem_read),
    .mem_addr(mem_addr), .Instruction(Instruction),
    .instruction_valid(instruction_valid), .pc(pc), .pc_plus_one(pc_plus_one)
  );

  always #5 clock = ~clock;

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [IW-1:0] mem_fn(input logic [DW-1:0] a);
    return a[IW-1:0] ^ 16'hA5C3;
  endfunction

  assign mem_data = mem_fn(mem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: either booting, waiting on memory, or holding a word.
  logic          m_boot, m_valid;
  logic [DW-1:0] m_addr, m_pc;
  logic [IW-1:0] m_instr;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_boot <= 1'b1; m_valid <= 1'b0;
      m_addr <= '0; m_pc <= '0; m_instr <= '0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (!m_valid) begin
      if (mem_ready) begin
        m_instr <= mem_fn(m_addr);
        m_pc    <= m_addr;
        m_valid <= 1'b1;
      end
    end else if (enable) begin
      m_addr  <= should_branch ? branch_target : m_pc + 32'd1;
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if ($time > 2) begin
      chk("m_valid", 64'(instruction_valid), 64'(m_valid));
      chk("m_read", 64'(mem_read), 64'(!m_boot && !m_valid));
      chk("m_addr", 64'(mem_addr), 64'(m_addr));
      chk("m_pc", 64'(pc), 64'(m_pc));
      chk("m_instr", 64'(Instruction), 64'(m_instr));
      chk("m_pcp1", 64'(pc_plus_one), 64'(32'(m_pc + 32'd1)));
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!instruction_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("wait_valid", 64'(instruction_valid), 64'd1);
  endtask

  // Retire the held instruction on the next edge, then drop enable.
  task automatic retire(input logic br, input logic [DW-1:0] tgt);
    enable = 1'b1; should_branch = br; branch_target = tgt;
    @(negedge clock);
    enable = 1'b0; should_branch = 1'b0;
    $display("retire br=%0d tgt=%0h -> mem_addr=%0h", br, tgt, mem_addr);
  endtask

  initial begin
    #1 reset = 1'b1;
    mem_ready = 1'b1;
    #2;
    chk("rst_read", 64'(mem_read), 64'd0);
    chk("rst_valid", 64'(instruction_valid), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset release with memory always ready.
    @(negedge clock);
    chk("boot_read", 64'(mem_read), 64'd1);
    chk("boot_addr", 64'(mem_addr), 64'd0);
    @(negedge clock);
    chk("first_valid", 64'(instruction_valid), 64'd1);
    chk("first_instr", 64'(Instruction), 64'hA5C3);
    chk("first_pc", 64'(pc), 64'd0);
    $display("fetch pc=%0h instr=%0h", pc, Instruction);

    // Sequential and branch retire from pc=5.
    retire(1'b1, 32'd5);
    wait_valid();
    chk("pc5", 64'(pc), 64'd5);
    chk("pc5_p1", 64'(pc_plus_one), 64'd6);
    retire(1'b0, 32'd0);
    chk("seq_addr", 64'(mem_addr), 64'd6);
    chk("seq_valid", 64'(instruction_valid), 64'd0);
    wait_valid();
    chk("pc6", 64'(pc), 64'd6);
    retire(1'b1, 32'h40);
    chk("br_addr", 64'(mem_addr), 64'h40);

    // Memory not ready for three cycles.
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("wait_read", 64'(mem_read), 64'd1);
      chk("wait_addr", 64'(mem_addr), 64'h40);
      chk("wait_valid0", 64'(instruction_valid), 64'd0);
    end
    mem_ready = 1'b1;
    @(negedge clock);
    chk("late_valid", 64'(instruction_valid), 64'd1);
    chk("late_pc", 64'(pc), 64'h40);
    chk("late_instr", 64'(Instruction), 64'hA583);

    // Ten-cycle stall with branch inputs toggling.
    for (int i = 0; i < 10; i++) begin
      should_branch = i[0];
      branch_target = 32'h100 + 32'(i);
      @(negedge clock);
      chk("stall_pc", 64'(pc), 64'h40);
      chk("stall_instr", 64'(Instruction), 64'hA583);
      chk("stall_read", 64'(mem_read), 64'd0);
    end
    should_branch = 1'b0;
    $display("stall done pc=%0h", pc);

    // Address wrap at the top of the space.
    retire(1'b1, 32'hFFFF_FFFF);
    wait_valid();
    chk("top_pc", 64'(pc), 64'hFFFF_FFFF);
    chk("top_p1", 64'(pc_plus_one), 64'd0);
    retire(1'b0, 32'd0);
    chk("wrap_addr", 64'(mem_addr), 64'd0);
    wait_valid();

    // Reset in the middle of a request with mem_ready high.
    retire(1'b1, 32'h1234);
    chk("pre_rst_addr", 64'(mem_addr), 64'h1234);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_read", 64'(mem_read), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_pc", 64'(pc), 64'd0);
    chk("mid_rst_instr", 64'(Instruction), 64'd0);
    repeat (2) @(negedge clock);
    chk("held_rst_valid", 64'(instruction_valid), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("refetch_read", 64'(mem_read), 64'd1);
    chk("refetch_addr", 64'(mem_addr), 64'd0);
    @(negedge clock);
    chk("refetch_valid", 64'(instruction_valid), 64'd1);
    chk("refetch_instr", 64'(Instruction), 64'hA5C3);
    $display("refetch pc=%0h instr=%0h", pc, Instruction);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
